i2c_cmd_arbiter: RTL and testbench
==================================

Name: i2c_cmd_arbiter

Overview:
- Shares the single 3-byte I2C sender (codec config path, 24-bit word = device addr byte + reg/data bytes) between two command sources.
- Port 0 is the power-up init sequencer; port 1 is runtime control (volume, mute, sample-rate changes).
- Grants one requester at a time, issues a one-cycle start to the sender, holds the word stable until the sender finishes, then returns a done pulse.
- A watchdog aborts transactions whose finish never arrives.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- TIMEOUT, 200000, max cycles spent in WAIT before abort; 0 disables the watchdog.
- DW, 24, command word width (3 bytes).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_req0_valid  in  1  port 0 has a command.
- i_req0_data  in  DW  port 0 command word.
- o_req0_ready  out  1  port 0 command accepted this cycle.
- o_req0_done  out  1  one-cycle pulse: port 0 transaction ended.
- i_req1_valid  in  1  port 1 has a command.
- i_req1_data  in  DW  port 1 command word.
- o_req1_ready  out  1  port 1 command accepted this cycle.
- o_req1_done  out  1  one-cycle pulse: port 1 transaction ended.
- o_i2c_start  out  1  start pulse to the sender.
- o_i2c_dat  out  DW  word to the sender.
- i_i2c_finished  in  1  sender finished a transaction.
- i_err_clr  in  1  clears the sticky timeout flag.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout_err  out  1  sticky: a watchdog abort has occurred.

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset is synchronous and active-high on i_rst.
- Reset (also when asserted mid-transaction):
  - state = IDLE; last_grant = 1, so port 0 is favoured first.
  - Outputs: o_i2c_start = 0, o_i2c_dat = 0, both done = 0, o_timeout_err = 0, timer = 0.
  - No done pulse is issued for an aborted in-flight command.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - o_req*_ready is combinational and equals (state==IDLE && grant==port && valid).
  - Grant rules:
    - Only one port valid: that port wins.
    - Both valid, PRIORITY_MODE=1: port 0 wins.
    - Both valid, PRIORITY_MODE=0: the port other than last_grant wins.
  - On a handshake:
    - Latch the data into o_i2c_dat and record grant into cur_port and last_grant.
    - Go to START.
  - No valid: stay in IDLE.
- START:
  - o_i2c_start = 1 for exactly this cycle; timer cleared; go to WAIT.
  - i_i2c_finished is ignored in START.
- WAIT:
  - o_i2c_start = 0; o_i2c_dat is held unchanged.
  - i_i2c_finished = 1: go to DONE.
  - Otherwise the timer increments.
  - If TIMEOUT != 0 and timer == TIMEOUT-1 with no finish: set o_timeout_err and go to DONE.
  - Finish and the timeout limit in the same cycle: finish wins, no error.
- DONE:
  - o_req{cur_port}_done = 1 for one cycle.
  - Go to IDLE; a new request can be accepted in the following cycle.
- Latency:
  - Handshake in cycle N.
  - Start in N+1; WAIT from N+2.
  - Finish in cycle M gives done in M+1; next accept possible in M+2.
  - Minimum 4 cycles between back-to-back accepts.
- Sticky error:
  - i_err_clr clears o_timeout_err.
  - Simultaneous set and clear: set wins.
- i_i2c_finished while in IDLE or DONE: ignored.
- Requester data/valid may change freely while not ready; only the word captured at the handshake is sent.
- Timer width: $clog2(TIMEOUT+1), minimum 1 bit; no wrap, it is only compared against the limit.
- o_busy = (state != IDLE).

Test Plan:
- Reset then single request: i_req0_valid=1, data=24'h340815, finished 10 cycles after start.
  - o_req0_ready in cycle N, start in N+1 with o_i2c_dat=24'h340815, o_req0_done exactly 1 cycle after finished, o_busy low afterwards.
- Contention, PRIORITY_MODE=0: both ports valid continuously with 24'h340A00 and 24'h340C00.
  - Grants alternate 0,1,0,1; each done goes only to the granted port; no port starves.
- Contention, PRIORITY_MODE=1: both ports valid continuously.
  - Port 0 is granted every time; port 1 is granted only after port 0 valid drops.
- Watchdog, TIMEOUT=16: finished never asserted.
  - Abort at the 16th WAIT cycle, o_timeout_err=1, done pulse on the granted port.
  - Pulse i_err_clr clears the flag; i_err_clr in the same cycle as a new timeout leaves the flag at 1.
- Boundary: finished asserted exactly on timer==TIMEOUT-1.
  - Normal completion, o_timeout_err stays 0.
  - finished pulsed in IDLE and in START causes no state change.
- Reset mid-WAIT: assert i_rst for 1 cycle.
  - Next cycle: IDLE, o_busy=0, no done pulse.
  - Next accepted request goes to port 0 when both ports are valid.

Source files
------------

// File: rtl/i2c_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2c_cmd_arbiter
// Description : Shares one 3-byte I2C sender between two command sources.
//               Port 0 is the power-up init sequencer and port 1 is runtime
//               control. One requester is granted at a time. The sender gets
//               a one-cycle start, the word is held until the sender reports
//               finish, and the granted port then sees a one-cycle done.
//               A watchdog aborts a transaction whose finish never arrives.
//
// Ports       : i_clk, i_rst            clock, synchronous active-high reset
//               i_req{0,1}_valid/data   command request per port
//               o_req{0,1}_ready        command accepted this cycle
//               o_req{0,1}_done         one-cycle end-of-transaction pulse
//               o_i2c_start/o_i2c_dat   start pulse and word to the sender
//               i_i2c_finished          sender finished a transaction
//               i_err_clr               clears the sticky timeout flag
//               o_busy                  arbiter is not idle
//               o_timeout_err           sticky watchdog-abort flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_arbiter #(
    parameter int PRIORITY_MODE = 0,      // 0: round-robin, 1: port 0 always wins
    parameter int TIMEOUT       = 200000, // WAIT cycles before abort, 0 disables
    parameter int DW            = 24      // command word width
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic [DW-1:0] i_req0_data,
    output logic          o_req0_ready,
    output logic          o_req0_done,
    input  logic          i_req1_valid,
    input  logic [DW-1:0] i_req1_data,
    output logic          o_req1_ready,
    output logic          o_req1_done,
    output logic          o_i2c_start,
    output logic [DW-1:0] o_i2c_dat,
    input  logic          i_i2c_finished,
    input  logic          i_err_clr,
    output logic          o_busy,
    output logic          o_timeout_err
);

    // Timer only needs to reach TIMEOUT-1; keep at least one bit so the
    // declaration stays legal when the watchdog is disabled.
    localparam int            TW            = (TIMEOUT > 0 && $clog2(TIMEOUT + 1) > 0)
                                              ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] c_timer_limit = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic          c_wdog_en     = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            r_cur_port;
    logic [TW-1:0]   r_timer;
    logic [DW-1:0]   r_dat;
    logic            r_timeout_err;
    logic            w_grant;
    logic            w_accept;
    logic            w_timeout;

    // Grant selection. With both ports valid, round-robin hands the bus to
    // the port that did not win last time; fixed priority always picks 0.
    always_comb begin
        w_grant = 1'b0;
        if (i_req1_valid && !i_req0_valid) begin
            w_grant = 1'b1;
        end else if (i_req0_valid && i_req1_valid) begin
            w_grant = (PRIORITY_MODE == 1) ? 1'b0 : ~r_last_grant;
        end
    end

    assign w_accept  = (r_state == S_IDLE) && (w_grant ? i_req1_valid : i_req0_valid);

    // Finish in the same cycle as the limit is a normal completion.
    assign w_timeout = c_wdog_en && (r_state == S_WAIT) && !i_i2c_finished
                       && (r_timer == c_timer_limit);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; finish is only honoured in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (i_i2c_finished || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: captured word, grant history, watchdog timer, sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant  <= 1'b1;  // port 0 is favoured on the first contention
            r_cur_port    <= 1'b0;
            r_dat         <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dat        <= w_grant ? i_req1_data : i_req0_data;
                r_cur_port   <= w_grant;
                r_last_grant <= w_grant;
            end

            if (r_state == S_START) begin
                r_timer <= '0;
            end else if ((r_state == S_WAIT) && !i_i2c_finished && (r_timer != '1)) begin
                r_timer <= r_timer + TW'(1);
            end

            // A new abort takes precedence over a clear in the same cycle.
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_req0_ready  = w_accept && !w_grant;
    assign o_req1_ready  = w_accept &&  w_grant;
    assign o_req0_done   = (r_state == S_DONE) && !r_cur_port;
    assign o_req1_done   = (r_state == S_DONE) &&  r_cur_port;
    assign o_i2c_start   = (r_state == S_START);
    assign o_i2c_dat     = r_dat;
    assign o_busy        = (r_state != S_IDLE);
    assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_cmd_arbiter
// Description : Directed self-checking bench. Two arbiters share one set of
//               stimulus: one round-robin, one fixed-priority, both with a
//               16-cycle watchdog. Their timing is identical; only the
//               granted port differs, so each has its own expected grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_arbiter;

    localparam int DW = 24;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0, fin = 1'b0, clr = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    logic          rr_ready0, rr_ready1, rr_done0, rr_done1, rr_start, rr_busy, rr_err;
    logic [DW-1:0] rr_dat;
    logic          fp_ready0, fp_ready1, fp_done0, fp_done1, fp_start, fp_busy, fp_err;
    logic [DW-1:0] fp_dat;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_cmd_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(TO), .DW(DW)) u_rr (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(rr_ready0), .o_req0_done(rr_done0),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(rr_ready1), .o_req1_done(rr_done1),
        .o_i2c_start(rr_start), .o_i2c_dat(rr_dat), .i_i2c_finished(fin),
        .i_err_clr(clr), .o_busy(rr_busy), .o_timeout_err(rr_err)
    );

    i2c_cmd_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(TO), .DW(DW)) u_fp (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(fp_ready0), .o_req0_done(fp_done0),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(fp_ready1), .o_req1_done(fp_done1),
        .o_i2c_start(fp_start), .o_i2c_dat(fp_dat), .i_i2c_finished(fin),
        .i_err_clr(clr), .o_busy(fp_busy), .o_timeout_err(fp_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_ready(input int g_rr, input int g_fp);
        chk("rr_ready0", 32'(rr_ready0), 32'(g_rr == 0));
        chk("rr_ready1", 32'(rr_ready1), 32'(g_rr == 1));
        chk("fp_ready0", 32'(fp_ready0), 32'(g_fp == 0));
        chk("fp_ready1", 32'(fp_ready1), 32'(g_fp == 1));
    endtask

    task automatic chk_done(input int g_rr, input int g_fp);
        chk("rr_done0", 32'(rr_done0), 32'(g_rr == 0));
        chk("rr_done1", 32'(rr_done1), 32'(g_rr == 1));
        chk("fp_done0", 32'(fp_done0), 32'(g_fp == 0));
        chk("fp_done1", 32'(fp_done1), 32'(g_fp == 1));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("rst_busy",  32'({rr_busy,  fp_busy}),  32'd0);
        chk("rst_start", 32'({rr_start, fp_start}), 32'd0);
        chk("rst_dat",   32'(rr_dat | fp_dat),      32'd0);
        chk("rst_done",  32'({rr_done0, rr_done1, fp_done0, fp_done1}), 32'd0);
        chk("rst_err",   32'({rr_err,   fp_err}),   32'd0);
    endtask

    // One full transaction starting in an IDLE cycle with valids already set.
    // lat = WAIT cycle index (timer value) at which finish is asserted;
    // fs = also pulse finish during START, which must be ignored.
    task automatic txn(input int g_rr, input int g_fp, input int lat, input bit fs);
        logic [DW-1:0] e_rr, e_fp, s0, s1;
        #1;
        chk_ready(g_rr, g_fp);
        e_rr = (g_rr == 1) ? d1 : d0;
        e_fp = (g_fp == 1) ? d1 : d0;
        s0 = d0;
        s1 = d1;
        tick();                         // START
        d0 = ~s0;                       // requester words change after capture
        d1 = ~s1;
        fin = fs;
        #1;
        chk("rr_start", 32'(rr_start), 32'd1);
        chk("fp_start", 32'(fp_start), 32'd1);
        chk("rr_dat_start", 32'(rr_dat), 32'(e_rr));
        chk("fp_dat_start", 32'(fp_dat), 32'(e_fp));
        chk("start_no_ready", 32'({rr_ready0, rr_ready1, fp_ready0, fp_ready1}), 32'd0);
        tick();                         // WAIT, timer 0
        fin = 1'b0;
        #1;
        chk("wait_no_done",  32'({rr_done0, rr_done1, fp_done0, fp_done1}), 32'd0);
        chk("wait_no_start", 32'({rr_start, fp_start}), 32'd0);
        chk("wait_busy",     32'({rr_busy, fp_busy}), 32'h3);
        repeat (lat) tick();
        fin = 1'b1;
        tick();                         // DONE
        fin = 1'b0;
        d0 = s0;
        d1 = s1;
        #1;
        chk_done(g_rr, g_fp);
        chk("rr_dat_hold", 32'(rr_dat), 32'(e_rr));
        chk("fp_dat_hold", 32'(fp_dat), 32'(e_fp));
        tick();                         // IDLE
    endtask

    // Transaction that never finishes: abort after the 16th WAIT cycle.
    // clr_last asserts i_err_clr in the same cycle the abort is detected.
    task automatic wd_txn(input int g_rr, input int g_fp, input bit clr_last);
        #1;
        chk_ready(g_rr, g_fp);
        tick();                         // START
        #1;
        chk("wd_start", 32'({rr_start, fp_start}), 32'h3);
        tick();                         // WAIT, timer 0
        repeat (TO - 1) tick();         // WAIT, timer TO-1
        clr = clr_last;
        #1;
        chk("wd_pre_done", 32'({rr_done0, rr_done1, fp_done0, fp_done1}), 32'd0);
        chk("wd_pre_busy", 32'({rr_busy, fp_busy}), 32'h3);
        chk("wd_pre_err",  32'({rr_err, fp_err}), 32'd0);
        tick();                         // DONE
        clr = 1'b0;
        #1;
        chk_done(g_rr, g_fp);
        chk("wd_err_set", 32'({rr_err, fp_err}), 32'h3);
        tick();                         // IDLE
        #1;
        chk("wd_err_sticky", 32'({rr_err, fp_err}), 32'h3);
        chk("wd_idle",       32'({rr_busy, fp_busy}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        do_reset();

        // Single request on port 0, finish 10 cycles after start.
        v0 = 1'b1;
        d0 = 24'h340815;
        txn(0, 0, 9, 1'b0);
        v0 = 1'b0;
        #1;
        chk("single_idle", 32'({rr_busy, fp_busy}), 32'd0);

        // Contention: round-robin alternates from port 0; fixed stays on 0.
        do_reset();
        v0 = 1'b1; v1 = 1'b1;
        d0 = 24'h340A00;
        d1 = 24'h340C00;
        txn(0, 0, 2, 1'b0);
        txn(1, 0, 2, 1'b1);             // finish during START is ignored
        txn(0, 0, TO - 1, 1'b0);        // finish exactly at the limit
        #1;
        chk("boundary_no_err", 32'({rr_err, fp_err}), 32'd0);
        txn(1, 0, 2, 1'b0);
        v0 = 1'b0;                      // port 1 now wins on the fixed arbiter
        txn(1, 1, 2, 1'b0);
        v1 = 1'b0;

        // Finish while IDLE is ignored.
        fin = 1'b1;
        tick();
        fin = 1'b0;
        #1;
        chk("idle_fin_busy", 32'({rr_busy, fp_busy}), 32'd0);
        chk("idle_fin_done", 32'({rr_done0, rr_done1, fp_done0, fp_done1}), 32'd0);

        // Watchdog abort, clear, then clear colliding with a new abort.
        v0 = 1'b1;
        d0 = 24'h341E00;
        wd_txn(0, 0, 1'b0);
        v0 = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("err_cleared", 32'({rr_err, fp_err}), 32'd0);
        v1 = 1'b1;
        d1 = 24'h340E02;
        wd_txn(1, 1, 1'b1);
        v1 = 1'b0;

        // Reset in the middle of WAIT; both ports valid.
        v0 = 1'b1; v1 = 1'b1;
        d0 = 24'h340A00;
        d1 = 24'h340C00;
        #1;
        chk_ready(0, 0);
        tick();                         // START
        tick();                         // WAIT 0
        tick();                         // WAIT 1
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        chk("mid_rst_busy",  32'({rr_busy, fp_busy}), 32'd0);
        chk("mid_rst_done",  32'({rr_done0, rr_done1, fp_done0, fp_done1}), 32'd0);
        chk("mid_rst_start", 32'({rr_start, fp_start}), 32'd0);
        chk("mid_rst_err",   32'({rr_err, fp_err}), 32'd0);
        chk("mid_rst_dat",   32'(rr_dat | fp_dat), 32'd0);
        txn(0, 0, 3, 1'b0);             // port 0 favoured again after reset
        txn(1, 0, 2, 1'b0);
        v0 = 1'b0; v1 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
